// File: rtl/rf_write_arbiter.sv
// Single register-file write-port arbiter: WB > pending overflow status > MD result FIFO.
// Optional `RF_ARB_STATS_EN adds saturating exc_count / md_wait_count outputs.
module rf_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STATUS_REG = 30,
    parameter int MD_DEPTH   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_exc,
    input  logic [DATA_W-1:0] wb_exc_code,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              status_busy
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]       exc_count,
    output logic [15:0]       md_wait_count
`endif
);

    localparam int PTR_W = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_REG);

    typedef enum logic {
        S_IDLE,
        S_PEND
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] code_q, code_d;

    logic [DATA_W-1:0] fifo_data_q [MD_DEPTH];
    logic [ADDR_W-1:0] fifo_rd_q   [MD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              fifo_full, fifo_empty, push, pop;
    logic              grant_st;
    logic              sel_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    assign fifo_full  = (cnt_q == CNT_W'(MD_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign md_ready   = !fifo_full;
    assign push       = md_valid && md_ready;
    // WB is never stalled, so the lower-priority sources only see idle WB cycles.
    assign grant_st   = !wb_valid && (state_q == S_PEND);
    assign pop        = !wb_valid && (state_q != S_PEND) && !fifo_empty;

    always_comb begin
        sel_vld  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        if (wb_valid) begin
            sel_vld  = 1'b1;
            sel_addr = wb_rd;
            sel_data = wb_exc ? '0 : wb_data;
        end else if (grant_st) begin
            sel_vld  = 1'b1;
            sel_addr = STATUS_ADDR;
            sel_data = code_q;
        end else if (pop) begin
            sel_vld  = 1'b1;
            sel_addr = fifo_rd_q[rd_ptr_q];
            sel_data = fifo_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (wb_valid && wb_exc) begin
            // Latest exception wins, even over a status write still pending.
            state_d = S_PEND;
            code_d  = wb_exc_code;
        end else if (state_q == S_PEND) begin
            if (grant_st || (wb_valid && wb_rd == STATUS_ADDR)) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    assign status_busy = (state_q == S_PEND);

    // Writes to register 0 consume the slot but never raise the enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= sel_vld && (sel_addr != '0);
            rf_waddr_q <= sel_addr;
            rf_wdata_q <= sel_data;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= md_data;
            fifo_rd_q[wr_ptr_q]   <= md_rd;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef RF_ARB_STATS_EN
    logic [15:0] exc_cnt_q;
    logic [15:0] wait_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exc_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            if (wb_valid && wb_exc && exc_cnt_q != 16'hFFFF) begin
                exc_cnt_q <= exc_cnt_q + 16'd1;
            end
            if (!fifo_empty && !pop && wait_cnt_q != 16'hFFFF) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
        end
    end

    assign exc_count     = exc_cnt_q;
    assign md_wait_count = wait_cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_rf_write_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STATUS_REG = 30;
    localparam int MD_DEPTH   = 2;

    logic              clock;
    logic              reset;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_exc;
    logic [DATA_W-1:0] wb_exc_code;
    logic              md_valid;
    logic [ADDR_W-1:0] md_rd;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              status_busy;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .STATUS_REG(STATUS_REG),
        .MD_DEPTH  (MD_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_exc     (wb_exc),
        .wb_exc_code(wb_exc_code),
        .md_valid   (md_valid),
        .md_rd      (md_rd),
        .md_data    (md_data),
        .md_ready   (md_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .status_busy(status_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one write slot per cycle, taken by WB, else the pending
    // status code, else the oldest queued MD result.
    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } md_t;

    md_t               mdq[$];
    bit                m_pend;
    logic [DATA_W-1:0] m_code;
    bit                e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;

    always @(posedge clock or negedge reset) begin
        bit                wrote;
        bit                acc;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        md_t               ent;
        if (!reset) begin
            mdq.delete();
            m_pend = 0;
            m_code = '0;
            e_we   = 0;
            e_addr = '0;
            e_data = '0;
        end else begin
            acc   = md_valid && (mdq.size() < MD_DEPTH);
            wrote = 0;
            a     = '0;
            d     = '0;
            if (wb_valid) begin
                wrote = 1;
                a     = wb_rd;
                d     = wb_exc ? '0 : wb_data;
            end else if (m_pend) begin
                wrote  = 1;
                a      = ADDR_W'(STATUS_REG);
                d      = m_code;
                m_pend = 0;
            end else if (mdq.size() > 0) begin
                wrote = 1;
                a     = mdq[0].rd;
                d     = mdq[0].data;
                void'(mdq.pop_front());
            end
            if (wb_valid && wb_exc) begin
                m_pend = 1;
                m_code = wb_exc_code;
            end else if (wb_valid && m_pend && wb_rd == ADDR_W'(STATUS_REG)) begin
                m_pend = 0;
            end
            if (acc) begin
                ent.rd   = md_rd;
                ent.data = md_data;
                mdq.push_back(ent);
            end
            e_we   = wrote && (a != '0);
            e_addr = a;
            e_data = d;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("model_rf_we", 32'(rf_we), 32'(e_we));
            if (e_we) begin
                chk("model_rf_waddr", 32'(rf_waddr), 32'(e_addr));
                chk("model_rf_wdata", rf_wdata, e_data);
            end
            chk("model_status_busy", 32'(status_busy), 32'(m_pend));
            chk("model_md_ready", 32'(md_ready), 32'(mdq.size() < MD_DEPTH));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wb_none();
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        wb_exc      = 1'b0;
        wb_exc_code = '0;
    endtask

    task automatic wb_wr(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        wb_valid    = 1'b1;
        wb_rd       = rd;
        wb_data     = data;
        wb_exc      = 1'b0;
        wb_exc_code = '0;
    endtask

    task automatic wb_ovf(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] code);
        wb_valid    = 1'b1;
        wb_rd       = rd;
        wb_data     = 32'hDEAD_BEEF;
        wb_exc      = 1'b1;
        wb_exc_code = code;
    endtask

    task automatic md_offer(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        md_valid = 1'b1;
        md_rd    = rd;
        md_data  = data;
    endtask

    task automatic md_none();
        md_valid = 1'b0;
        md_rd    = '0;
        md_data  = '0;
    endtask

    task automatic expect_write(input string name, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d);
        chk({name, "_we"}, 32'(rf_we), 32'd1);
        chk({name, "_waddr"}, 32'(rf_waddr), 32'(a));
        chk({name, "_wdata"}, rf_wdata, d);
    endtask

    initial begin
        reset = 1'b0;
        wb_none();
        md_none();
        #12;
        chk("reset_we", 32'(rf_we), 32'd0);
        chk("reset_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_wdata", rf_wdata, 32'd0);
        chk("reset_busy", 32'(status_busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("post_reset_md_ready", 32'(md_ready), 32'd1);

        // Plain WB write
        wb_wr(5'd1, 32'd5);
        step();
        expect_write("t1", 5'd1, 32'd5);
        wb_none();
        step();
        chk("t1_idle_we", 32'(rf_we), 32'd0);

        // Overflow: rd<=0 then status register <= code
        wb_ovf(5'd21, 32'd1);
        step();
        expect_write("t2_rd", 5'd21, 32'd0);
        chk("t2_busy_set", 32'(status_busy), 32'd1);
        wb_none();
        step();
        expect_write("t2_st", 5'd30, 32'd1);
        chk("t2_busy_clr", 32'(status_busy), 32'd0);
        step();
        chk("t2_idle_we", 32'(rf_we), 32'd0);

        // Overflow shadowed by WB traffic, re-overflow replaces the code
        wb_ovf(5'd8, 32'd2);
        step();
        wb_wr(5'd9, 32'h99);
        step();
        chk("t3_busy_hold", 32'(status_busy), 32'd1);
        wb_ovf(5'd10, 32'd3);
        step();
        wb_wr(5'd11, 32'h77);
        step();
        expect_write("t3_wb", 5'd11, 32'h77);
        wb_none();
        step();
        expect_write("t3_st", 5'd30, 32'd3);
        step();
        chk("t3_once_we", 32'(rf_we), 32'd0);

        // MD results queued behind WB, drained in order
        wb_wr(5'd2, 32'h200);
        md_offer(5'd5, 32'd10);
        step();
        wb_wr(5'd3, 32'h300);
        md_offer(5'd6, 32'd20);
        step();
        chk("t4_full_ready", 32'(md_ready), 32'd0);
        wb_wr(5'd4, 32'h400);
        md_offer(5'd7, 32'd30);
        step();
        chk("t4_still_full", 32'(md_ready), 32'd0);
        wb_none();
        step();
        expect_write("t4_md0", 5'd5, 32'd10);
        chk("t4_ready_again", 32'(md_ready), 32'd1);
        step();
        expect_write("t4_md1", 5'd6, 32'd20);
        md_none();
        step();
        expect_write("t4_md2", 5'd7, 32'd30);
        step();
        chk("t4_drained_we", 32'(rf_we), 32'd0);

        // Register 0 and overflow targeting the status register
        wb_wr(5'd0, 32'd9);
        step();
        chk("t5_r0_we", 32'(rf_we), 32'd0);
        wb_ovf(5'd30, 32'd1);
        step();
        expect_write("t5_zero", 5'd30, 32'd0);
        wb_none();
        step();
        expect_write("t5_code", 5'd30, 32'd1);

        // WB plain write to status register cancels a pending code
        wb_ovf(5'd12, 32'd2);
        step();
        wb_wr(5'd30, 32'h1234);
        step();
        expect_write("t5b_wb", 5'd30, 32'h1234);
        chk("t5b_cancel_busy", 32'(status_busy), 32'd0);
        wb_none();
        step();
        chk("t5b_no_status_we", 32'(rf_we), 32'd0);

        // Asynchronous reset with queued MD results and a pending code
        wb_wr(5'd2, 32'h1);
        md_offer(5'd1, 32'h11);
        step();
        wb_wr(5'd3, 32'h2);
        md_offer(5'd2, 32'h22);
        step();
        wb_ovf(5'd4, 32'd3);
        md_none();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_we", 32'(rf_we), 32'd0);
        chk("t6_rst_waddr", 32'(rf_waddr), 32'd0);
        chk("t6_rst_wdata", rf_wdata, 32'd0);
        chk("t6_rst_busy", 32'(status_busy), 32'd0);
        chk("t6_rst_ready", 32'(md_ready), 32'd1);
        wb_none();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_stale_we", 32'(rf_we), 32'd0);
        end

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
